// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line-level constants
// common to the transmitter and receiver.
package uart_pkg;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Cycles from the detected falling edge to the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned divisor);
    return divisor / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value is chosen per
// use so an idle line does not look like an edge when reset is released.
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make both flops load their pre-edge values,
  // giving a true two-stage pipeline; blocking would collapse it to one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous-serial receiver: start/WIDTH data (LSB first)/stop frames are
// sampled mid-bit and presented on a valid/ready interface.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 86
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_rx,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int CW = $clog2(DIVISOR);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] HALF_LOAD = CW'(half_bit(DIVISOR) - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  uart_rx_state_t   state;
  logic             rx_s;
  logic             rx_prev;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (UART_IDLE)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (i_reset),
    .d     (i_rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      rx_prev     <= UART_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      // NOTE: the shift register is reset along with the control state; it is
      // small, and a defined value keeps o_data free of X after a restart.
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      rx_prev     <= rx_s;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;

      // A later commit in this same cycle overrides this clear.
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_enable && rx_prev == UART_IDLE && rx_s == UART_START) begin
            cnt    <= HALF_LOAD;
            state  <= START;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == '0) begin
            if (rx_s == UART_START) begin
              cnt     <= FULL_LOAD;
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            // New bit enters at the MSB so the first bit ends up as the LSB.
            shift <= WIDTH'({rx_s, shift} >> 1);
            cnt   <= FULL_LOAD;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            if (rx_s == UART_IDLE) begin
              if (!o_valid || i_ready) begin
                o_data  <= shift;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        BREAK: begin
          if (rx_s == UART_IDLE) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous-serial receiver that sits directly downstream of `fifo_uart`. It consumes the 8N1-style line driven by `o_tx` (idle high, one start bit, WIDTH data bits LSB first, one stop bit) and recovers parallel words on a valid/ready interface. It closes the test-counter loopback path, so words written into the transmit FIFO can be checked on the receive side. Bit timing uses the same `DIVISOR` (system clocks per bit) as the transmitter, so both ends agree by construction.

## Interface
- `WIDTH`, 8, data bits per frame.
- `DIVISOR`, 86, clk cycles per bit. Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `i_reset`  in  1  asynchronous, active-low reset (0 = reset).
- `i_enable`  in  1  1 = arm receiver. Sampled only in IDLE.
- `i_rx`  in  1  serial line, asynchronous to clk, idle high.
- `i_ready`  in  1  consumer accepts `o_data` when `o_valid & i_ready`.
- `o_data`  out  WIDTH  received word; stable while `o_valid`=1.
- `o_valid`  out  1  word available; held until accepted.
- `o_frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `o_overrun`  out  1  one-cycle pulse when a good word is dropped.
- `o_busy`  out  1  1 in any state other than IDLE.

## Operation
- `i_rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- Reset values: all outputs 0, state IDLE, `o_data`=0, synchronizer flops reset to 1 (idle line).
- FSM states and transitions:
  - **IDLE**: when `i_enable`=1 and `rx_s` falls from 1 to 0, load the counter and go to START.
  - **START**: wait DIVISOR/2 cycles, then sample.
    - `rx_s`=1: false start, return to IDLE with no flags.
    - `rx_s`=0: go to DATA.
  - **DATA**: sample every DIVISOR cycles, shifting right with the new bit entering at the MSB, so the first bit becomes the LSB. After WIDTH samples, go to STOP.
  - **STOP**: sample after DIVISOR cycles.
    - 1: commit the word and go to IDLE. The remaining half stop bit is not waited out, so back-to-back frames are accepted.
    - 0: pulse `o_frame_err`, discard the word, go to BREAK.
  - **BREAK**: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- Bit counter is $clog2(WIDTH+1) bits wide; cycle counter is $clog2(DIVISOR) bits wide, counting down to 0.
- Commit rules:
  - `o_valid`=0: load `o_data` and set `o_valid`.
  - `o_valid`=1 with `i_ready`=1 in the same cycle: the old word is consumed; load the new word and keep `o_valid`=1. No overrun.
  - `o_valid`=1 with `i_ready`=0: keep the old word, pulse `o_overrun`, drop the new word.
- `i_enable` dropping mid-frame: the current frame completes normally, and the receiver then stays in IDLE.
- `i_reset` asserted mid-frame: immediate return to reset values; any partial word is lost.

## Timing
- Synchronizer latency: 2 cycles.
- Sample points, counted from the IDLE cycle that detects the edge:
  - start bit at +DIVISOR/2;
  - data bit k at +DIVISOR/2 + (k+1)·DIVISOR;
  - stop bit at +DIVISOR/2 + (WIDTH+1)·DIVISOR.
- `o_valid` rises 1 cycle after the stop sample. Total latency from the first clk edge that sees `i_rx`=0 is 2 + DIVISOR/2 + (WIDTH+1)·DIVISOR + 1. With the defaults this is 820 cycles.
- `o_valid` clears on the cycle after `o_valid & i_ready`, unless a word commits in that same cycle.
- `o_frame_err` and `o_overrun` are registered and exactly 1 cycle wide.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum: IDLE, START, DATA, STOP, BREAK;
  - line-level constants `UART_IDLE`=1'b1 and `UART_START`=1'b0, shared with the transmitter.
- Sub-module `sync_2ff` (parameterized reset value) for `i_rx`; it is reusable for other asynchronous inputs.

## Test plan
- Loopback from `fifo_uart` with matched DIVISOR; write 0xA5, 0x3C, 0xFF, 0x00 with `i_ready`=1 → each word appears on `o_data` in order, and the first `o_valid` comes 820 cycles after its start bit.
- Glitch: drive `i_rx` low for 20 cycles (< DIVISOR/2 = 43) → no `o_valid`, no `o_frame_err`, `o_busy` returns to 0.
- Framing error: send 0x55 with the stop bit forced to 0, then hold the line low for 3 bit times → a single `o_frame_err` pulse, no `o_valid`, FSM stays in BREAK until the line goes high. A following 0x81 is received correctly.
- Overrun: hold `i_ready`=0 and send 0x12 then 0x34 → `o_data`=0x12 is retained, one `o_overrun` pulse occurs at the second commit, and raising `i_ready` yields only 0x12.
- Simultaneous accept/commit: assert `i_ready` for exactly the commit cycle of the second word → no overrun, and `o_data` changes from 0x12 to 0x34 with `o_valid` staying 1.
- Reset mid-frame: pull `i_reset` low during DATA bit 4 for 3 cycles → outputs go to 0 immediately, the partial word is never presented, and the next full frame 0xC3 is received correctly.
